// File: rtl/barrel_shift_pipe.sv
// Four-stage pipelined left shifter/rotator (8,4,2,1 stages), one result per clock.
// Latency 4 cycles plus one per stall cycle; a global stall holds every stage while out_valid && !out_ready.
module barrel_shift_pipe #(
   parameter int WIDTH = 16,
   parameter int SHW   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SHW-1:0]   in_shamt,
   input  logic             in_rot,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [2:0]       occupancy
);

   typedef struct packed {
      logic             vld;
      logic             rot;
      logic [SHW-1:0]   shamt;
      logic [WIDTH-1:0] dat;
   } stage_t;

   stage_t stg_q [SHW];
   stage_t stg_d [SHW];
   stage_t prev  [SHW];
   stage_t in_pkt;
   logic   advance;

   assign in_pkt   = '{vld: in_valid, rot: in_rot, shamt: in_shamt, dat: in_data};
   assign advance  = !stg_q[SHW-1].vld || out_ready;
   assign in_ready = advance;

   // Stage k consumes shamt bit SHW-1-k, i.e. the largest remaining power of two first.
   always_comb begin
      prev[0] = in_pkt;
      for (int k = 1; k < SHW; k++) begin
         prev[k] = stg_q[k-1];
      end
      for (int k = 0; k < SHW; k++) begin
         stg_d[k] = prev[k];
         if (prev[k].shamt[SHW-1-k]) begin
            if (prev[k].rot) begin
               stg_d[k].dat = (prev[k].dat << (1 << (SHW-1-k)))
                            | (prev[k].dat >> (WIDTH - (1 << (SHW-1-k))));
            end else begin
               stg_d[k].dat = prev[k].dat << (1 << (SHW-1-k));
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < SHW; k++) begin
            stg_q[k] <= '0;
         end
      end else if (advance) begin
         for (int k = 0; k < SHW; k++) begin
            stg_q[k] <= stg_d[k];
         end
      end
   end

   always_comb begin
      occupancy = '0;
      for (int k = 0; k < SHW; k++) begin
         occupancy = occupancy + 3'(stg_q[k].vld);
      end
   end

   assign out_valid = stg_q[SHW-1].vld;
   assign out_data  = stg_q[SHW-1].dat;

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Directed bench for barrel_shift_pipe: latency, shift/rotate results, backpressure, bubbles, reset.
module tb_barrel_shift_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic [3:0]  in_shamt;
   logic        in_rot;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic [2:0]  occupancy;

   int tests = 0;
   int fails = 0;

   barrel_shift_pipe #(.WIDTH(16), .SHW(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_shamt  (in_shamt),
      .in_rot    (in_rot),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occupancy (occupancy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [15:0] d, input logic [3:0] sh, input logic r);
      in_valid = v;
      in_data  = d;
      in_shamt = sh;
      in_rot   = r;
   endtask

   // Single request through an idle pipe: checks latency, result and drain.
   task automatic send_one(input string tag, input logic [15:0] d, input logic [3:0] sh,
                           input logic r, input logic [15:0] exp);
      drive(1'b1, d, sh, r);
      #1 chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      tick();
      drive(1'b0, 16'h0, 4'h0, 1'b0);
      chk({tag, "_occ1"}, 32'(occupancy), 32'd1);
      tick();
      tick();
      chk({tag, "_early"}, 32'(out_valid), 32'd0);
      tick();
      chk({tag, "_vld"}, 32'(out_valid), 32'd1);
      chk({tag, "_dat"}, 32'(out_data), 32'(exp));
      tick();
      chk({tag, "_vld_off"}, 32'(out_valid), 32'd0);
      chk({tag, "_occ0"}, 32'(occupancy), 32'd0);
   endtask

   logic [15:0] b2b_exp [4];
   logic [15:0] bp_exp  [4];

   initial begin
      rst_n     = 1'b0;
      out_ready = 1'b1;
      drive(1'b0, 16'h0, 4'h0, 1'b0);
      #2;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data",  32'(out_data),  32'd0);
      chk("rst_occ",       32'(occupancy), 32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      tick();
      tick();
      rst_n = 1'b1;

      send_one("lsl8",   16'hAAAA, 4'd8,  1'b0, 16'hAA00);
      send_one("rol4",   16'hF0F0, 4'd4,  1'b1, 16'h0F0F);
      send_one("rol1",   16'h8001, 4'd1,  1'b1, 16'h0003);
      send_one("lsl15",  16'h8001, 4'd15, 1'b0, 16'h8000);
      send_one("rot0",   16'hBEEF, 4'd0,  1'b1, 16'hBEEF);

      // Back-to-back: result j appears after edge j+3.
      b2b_exp = '{16'h1234, 16'h2468, 16'h48D0, 16'h91A0};
      for (int i = 0; i < 7; i++) begin
         if (i < 4) drive(1'b1, 16'h1234, 4'(i), 1'b0);
         else       drive(1'b0, 16'h0, 4'h0, 1'b0);
         #1 chk("b2b_in_ready", 32'(in_ready), 32'd1);
         tick();
         if (i >= 3) begin
            chk("b2b_vld", 32'(out_valid), 32'd1);
            chk("b2b_dat", 32'(out_data), 32'(b2b_exp[i-3]));
         end
      end
      tick();
      chk("b2b_drained", 32'(out_valid), 32'd0);

      // Backpressure: fill, stall three cycles with a fifth request pending.
      bp_exp = '{16'h0002, 16'h0004, 16'h0008, 16'h0010};
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 16'h0001, 4'(i), 1'b0);
         tick();
      end
      chk("bp_full_occ", 32'(occupancy), 32'd4);
      chk("bp_head",     32'(out_data),  32'h0001);
      out_ready = 1'b0;
      drive(1'b1, 16'h0010, 4'd0, 1'b1);
      #1 chk("bp_in_ready0", 32'(in_ready), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_stall_occ",   32'(occupancy), 32'd4);
         chk("bp_stall_vld",   32'(out_valid), 32'd1);
         chk("bp_stall_dat",   32'(out_data),  32'h0001);
         chk("bp_stall_ready", 32'(in_ready),  32'd0);
      end
      out_ready = 1'b1;
      #1 chk("bp_in_ready1", 32'(in_ready), 32'd1);
      for (int i = 0; i < 4; i++) begin
         tick();
         if (i == 0) drive(1'b0, 16'h0, 4'h0, 1'b0);
         chk("bp_drain_vld", 32'(out_valid), 32'd1);
         chk("bp_drain_dat", 32'(out_data),  32'(bp_exp[i]));
      end
      tick();
      chk("bp_empty_vld", 32'(out_valid), 32'd0);
      chk("bp_empty_occ", 32'(occupancy), 32'd0);

      // Bubble between two requests.
      drive(1'b1, 16'hCCCC, 4'd2, 1'b0);
      tick();
      drive(1'b0, 16'h0, 4'h0, 1'b0);
      tick();
      drive(1'b1, 16'h00FF, 4'd8, 1'b1);
      tick();
      drive(1'b0, 16'h0, 4'h0, 1'b0);
      tick();
      chk("bub_a_vld", 32'(out_valid), 32'd1);
      chk("bub_a_dat", 32'(out_data),  32'h3330);
      tick();
      chk("bub_gap",   32'(out_valid), 32'd0);
      tick();
      chk("bub_b_vld", 32'(out_valid), 32'd1);
      chk("bub_b_dat", 32'(out_data),  32'hFF00);
      tick();
      chk("bub_end",   32'(out_valid), 32'd0);

      // Reset with three entries in flight.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 16'h5A5A, 4'(i + 1), 1'b1);
         tick();
      end
      drive(1'b0, 16'h0, 4'h0, 1'b0);
      chk("mid_occ3", 32'(occupancy), 32'd3);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_vld", 32'(out_valid), 32'd0);
      chk("mid_rst_dat", 32'(out_data),  32'd0);
      chk("mid_rst_occ", 32'(occupancy), 32'd0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("post_rst_vld", 32'(out_valid), 32'd0);
      end
      chk("post_rst_occ", 32'(occupancy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
